// File: rtl/cache_refill_ctrl_pkg.sv
// Shared constants and state encoding for the cache refill/writeback controller.
package cache_refill_ctrl_pkg;

    localparam int LINE_WORDS = 16;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;
    localparam int CNT_W      = $clog2(LINE_WORDS);

    // Reset is asserted when rst equals this value.
    localparam logic RstEnable = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_FIN,
        ST_RD,
        ST_FILL
    } state_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Serialises victim writebacks and line refills into single-word beats on a
// 32-bit memory bus; one optional writeback phase precedes every read phase.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              miss,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              accept,
    input  logic              wen_back,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LINE_W-1:0] wback,
    output logic              fin,
    output logic              wen_fill,
    output logic [LINE_W-1:0] wfill,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_t              state_reg, state_next;
    logic                accept_reg, accept_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   rd_base_reg, rd_base_next;
    logic [ADDR_W-1:0]   wb_base_reg, wb_base_next;
    logic [LINE_W-1:0]   wb_line_reg, wb_line_next;
    logic [LINE_W-1:0]   wfill_reg, wfill_next;
    logic [ADDR_W-1:0]   beat_offset;
    logic                last_beat;

    assign beat_offset = ADDR_W'(cnt_reg) << 2;
    assign last_beat   = (cnt_reg == CNT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_reg   <= ST_IDLE;
            accept_reg  <= 1'b0;
            cnt_reg     <= '0;
            rd_base_reg <= '0;
            wb_base_reg <= '0;
            wb_line_reg <= '0;
            wfill_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            accept_reg  <= accept_next;
            cnt_reg     <= cnt_next;
            rd_base_reg <= rd_base_next;
            wb_base_reg <= wb_base_next;
            wb_line_reg <= wb_line_next;
            wfill_reg   <= wfill_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        accept_next  = 1'b0;
        cnt_next     = cnt_reg;
        rd_base_next = rd_base_reg;
        wb_base_next = wb_base_reg;
        wb_line_next = wb_line_reg;
        wfill_next   = wfill_reg;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fin          = 1'b0;
        wen_fill     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // wen_back only counts when it arrives together with a miss
                if (miss) begin
                    rd_base_next = miss_addr;
                    accept_next  = 1'b1;
                    if (wen_back) begin
                        wb_base_next = waddr;
                        wb_line_next = wback;
                        state_next   = ST_WB;
                    end else begin
                        state_next   = ST_RD;
                    end
                end
            end
            ST_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_base_reg + beat_offset;
                mem_wdata = wb_line_reg[cnt_reg*WORD_W +: WORD_W];
                if (mem_ready) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (last_beat) begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                fin        = 1'b1;
                state_next = ST_RD;
            end
            ST_RD: begin
                mem_req  = 1'b1;
                mem_addr = rd_base_reg + beat_offset;
                if (mem_ready) begin
                    wfill_next[cnt_reg*WORD_W +: WORD_W] = mem_rdata;
                    cnt_next = cnt_reg + 1'b1;
                    if (last_beat) begin
                        state_next = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                wen_fill   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign accept = accept_reg;
    assign wfill  = wfill_reg;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: table of miss scenarios plus
// hand-written reset, stray-writeback and back-to-back sequences.
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss;
    logic [31:0]  miss_addr;
    logic         accept;
    logic         wen_back;
    logic [31:0]  waddr;
    logic [511:0] wback;
    logic         fin;
    logic         wen_fill;
    logic [511:0] wfill;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic [31:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    always #5 clk = ~clk;

    // Memory model: word at address A reads as A ^ PAT.
    assign mem_rdata = mem_addr ^ PAT;

    cache_refill_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .miss      (miss),
        .miss_addr (miss_addr),
        .accept    (accept),
        .wen_back  (wen_back),
        .waddr     (waddr),
        .wback     (wback),
        .fin       (fin),
        .wen_fill  (wen_fill),
        .wfill     (wfill),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic [31:0] maddr;
        logic        wb;
        logic [31:0] wb_addr;
        logic        stall;
        logic        chain;
        int          exp_acc;
        int          exp_fin;
        int          exp_fill;
    } scn_t;

    scn_t tbl [6];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scn(input scn_t s, input bit pre_set, input int idx, input logic [31:0] next_addr);
        int cyc = 0, acc_c = 0, fin_c = 0, fill_c = 0, wr_k = 0, rd_k = 0;
        bit phase = 1'b0;
        bit done = 1'b0;
        logic [511:0] exp_line;
        for (int i = 0; i < 16; i++) exp_line[i*32 +: 32] = (s.maddr + 32'(4*i)) ^ PAT;
        if (!pre_set) begin
            step();
            miss = 1'b1; miss_addr = s.maddr; wen_back = s.wb; waddr = s.wb_addr;
        end
        step();
        cyc = 1;
        while (!done && cyc < 200) begin
            mem_ready = 1'b1;
            if (s.stall && mem_req && !mem_we) begin
                mem_ready = phase;
                phase = ~phase;
            end
            if (accept) begin
                if (acc_c == 0) acc_c = cyc;
                miss = 1'b0; wen_back = 1'b0;
            end
            if (fin) fin_c = cyc;
            if (mem_req && mem_we) begin
                chk("wb_addr", mem_addr, s.wb_addr + 32'(4*wr_k));
                chk("wb_data", mem_wdata, 32'(wr_k));
                if (mem_ready) wr_k++;
            end
            if (mem_req && !mem_we) begin
                chk("rd_addr", mem_addr, s.maddr + 32'(4*rd_k));
                if (mem_ready) rd_k++;
            end
            if (wen_fill) begin
                fill_c = cyc;
                done = 1'b1;
                chk("wfill", wfill, exp_line);
                if (s.chain) begin
                    miss = 1'b1; miss_addr = next_addr; wen_back = 1'b0;
                end
            end else begin
                step();
                cyc++;
            end
        end
        chk("accept_cycle", 512'(acc_c), 512'(s.exp_acc));
        chk("fin_cycle", 512'(fin_c), 512'(s.exp_fin));
        chk("fill_cycle", 512'(fill_c), 512'(s.exp_fill));
        chk("wb_beats", 512'(wr_k), s.wb ? 512'd16 : 512'd0);
        chk("rd_beats", 512'(rd_k), 512'd16);
        $display("scn %0d: miss_addr=%h wb=%0d stall=%0d accept@%0d fin@%0d fill@%0d word0=%h",
                 idx, s.maddr, s.wb, s.stall, acc_c, fin_c, fill_c, wfill[31:0]);
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_mem_req"}, 512'(mem_req), 512'd0);
        chk({tag, "_mem_we"}, 512'(mem_we), 512'd0);
        chk({tag, "_mem_addr"}, 512'(mem_addr), 512'd0);
        chk({tag, "_mem_wdata"}, 512'(mem_wdata), 512'd0);
        chk({tag, "_accept"}, 512'(accept), 512'd0);
        chk({tag, "_fin"}, 512'(fin), 512'd0);
        chk({tag, "_wen_fill"}, 512'(wen_fill), 512'd0);
        chk({tag, "_wfill"}, wfill, 512'd0);
    endtask

    initial begin
        int req_cnt, fin_cnt, fill_cnt;
        bit pre;
        bit hit;
        rst = 1'b0; miss = 1'b0; miss_addr = '0; wen_back = 1'b0; waddr = '0; mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) wback[i*32 +: 32] = 32'(i);

        //            maddr          wb    wb_addr        stall chain acc fin fill
        tbl[0] = '{32'h0000_1040, 1'b0, 32'h0,         1'b0, 1'b0, 1, 0,  17};
        tbl[1] = '{32'h0000_3080, 1'b1, 32'h0000_2040, 1'b0, 1'b0, 1, 17, 34};
        tbl[2] = '{32'h0000_1040, 1'b0, 32'h0,         1'b1, 1'b0, 1, 0,  33};
        tbl[3] = '{32'h0000_5000, 1'b0, 32'h0,         1'b0, 1'b1, 1, 0,  17};
        tbl[4] = '{32'h0000_4000, 1'b0, 32'h0,         1'b0, 1'b0, 2, 0,  18};
        tbl[5] = '{32'h0000_6040, 1'b1, 32'h0000_7000, 1'b1, 1'b0, 1, 17, 50};

        step();
        step();
        chk_quiet_outputs("reset");
        rst = 1'b1;

        pre = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_scn(tbl[i], pre, i, (i < 5) ? tbl[i+1].maddr : 32'h0);
            pre = tbl[i].chain;
        end

        // Stray wen_back without miss: must be ignored.
        step();
        wen_back = 1'b1; waddr = 32'h0000_2040;
        req_cnt = 0; fin_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (mem_req) req_cnt++;
            if (fin) fin_cnt++;
        end
        wen_back = 1'b0;
        chk("stray_mem_req", 512'(req_cnt), 512'd0);
        chk("stray_fin", 512'(fin_cnt), 512'd0);
        $display("stray wen_back: req_cycles=%0d fin_cycles=%0d", req_cnt, fin_cnt);

        // Reset in the middle of a writeback burst at beat 7.
        step();
        miss = 1'b1; miss_addr = 32'h0000_3000; wen_back = 1'b1; waddr = 32'h0000_2040;
        step();
        miss = 1'b0; wen_back = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (mem_req && mem_we && mem_addr == 32'h0000_205C) hit = 1'b1;
            else step();
        end
        chk("reach_beat7", 512'(hit), 512'd1);
        rst = 1'b0;
        step();
        chk_quiet_outputs("midwb_reset");
        rst = 1'b1;
        req_cnt = 0; fin_cnt = 0; fill_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mem_req) req_cnt++;
            if (fin) fin_cnt++;
            if (wen_fill) fill_cnt++;
        end
        chk("post_reset_req", 512'(req_cnt), 512'd0);
        chk("post_reset_fin", 512'(fin_cnt), 512'd0);
        chk("post_reset_fill", 512'(fill_cnt), 512'd0);
        $display("reset mid-WB: req=%0d fin=%0d fill=%0d after release", req_cnt, fin_cnt, fill_cnt);
        run_scn(tbl[0], 1'b0, 6, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Memory-side refill/writeback controller that sits directly downstream of the 2-way data cache. It consumes the cache's miss request (`miss`/`miss_addr`/`accept`) and victim writeback (`wen_back`/`waddr`/`wback`/`fin`), serialises each 512-bit line into 16 single-word beats on a simple 32-bit memory bus, and returns the refilled line through `wen_fill`/`wfill`. Every miss produces exactly one optional writeback phase followed by one read phase.

## Interface
- `LINE_WORDS`, 16: words per cache line; fixed by the 512-bit line, 32-bit bus.
- `clk` input 1: sole clock.
- `rst` input 1: reset, synchronous, active-low (`rst==0` resets on the rising edge of `clk`).
- `miss` input 1: cache miss request; held by the cache until `accept`.
- `miss_addr` input 32: line-aligned miss address (`[5:0]==0`).
- `accept` output 1: one-cycle pulse acknowledging `miss`.
- `wen_back` input 1: victim writeback request.
- `waddr` input 32: victim line address.
- `wback` input 512: victim line data, word i at `[i*32+:32]`.
- `fin` output 1: one-cycle pulse when writeback has completed on the bus.
- `wen_fill` output 1: one-cycle pulse; `wfill` is valid.
- `wfill` output 512: refilled line, word i at `[i*32+:32]`.
- `mem_req` output 1: bus beat request.
- `mem_we` output 1: 1 = write beat, 0 = read beat.
- `mem_addr` output 32: beat word address.
- `mem_wdata` output 32: write beat data.
- `mem_ready` input 1: beat completes in any cycle with `mem_req && mem_ready`.
- `mem_rdata` input 32: read data, valid in the completing cycle.

## Operation
- States: IDLE, WB, FIN, RD, FILL. The state is in a register; `accept` is a register; all other control outputs decode from the state register, the beat counter and the latches.
- IDLE, `miss==1`:
  - latch `miss_addr` as `rd_base`;
  - set `accept<=1`;
  - if `wen_back==1` in the same cycle, latch `waddr`/`wback` and go to WB; otherwise go to RD.
- `wen_back` is honoured only in IDLE with `miss` high. It is ignored everywhere else, including the stray `wen_back` the cache holds after a fill.
- WB:
  - `mem_req=1`, `mem_we=1`, `mem_addr=wb_base+4*cnt`, `mem_wdata=wb_line[cnt*32+:32]`.
  - `cnt` (4-bit) increments on each completed beat.
  - A completed beat at `cnt==15` wraps `cnt` to 0 and moves to FIN.
- FIN: `fin=1` for exactly one cycle, then RD.
- RD:
  - `mem_req=1`, `mem_we=0`, `mem_addr=rd_base+4*cnt`.
  - On each completed beat, write `mem_rdata` into `wfill[cnt*32+:32]`.
  - A completed beat at `cnt==15` moves to FILL.
- FILL: `wen_fill=1` for one cycle, then IDLE. `wfill` holds its value until the next RD beat overwrites it.
- Outside WB/RD: `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- `mem_ready` stalls of any length leave the address, data and `cnt` unchanged.
- Reset values: `accept`, `fin`, `wen_fill`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `wfill` = 0; state = IDLE; `cnt`, latches = 0.
- Reset mid-burst: abort immediately, return to IDLE, drop `mem_req` the same edge. No `fin` and no `wen_fill` are issued.
- Address arithmetic is 32-bit. A line never crosses its 64-byte boundary, since bases are line-aligned and `cnt ≤ 15`.

## Timing
- With `mem_ready` tied to 1 and `miss` sampled in IDLE at cycle 0:
  - `accept` = cycle 1; WB beats = cycles 1–16; `fin` = cycle 17; RD beats = cycles 18–33; `wen_fill` = cycle 34; IDLE = cycle 35.
- Without writeback: `accept` = cycle 1; RD beats = cycles 1–16; `wen_fill` = cycle 17.
- Each `mem_ready`-low cycle adds one cycle of latency.
- A new `miss` is sampled no earlier than the IDLE cycle after FILL. Back-to-back misses therefore have a 1-cycle IDLE gap.

## Structure
- State encodings, `LINE_WORDS`, and bus-width constants go in the shared defines header. Reset sense uses the header's `RstEnable` set to 1'b0 for this block.
- Single module, no sub-modules: the line serializer and deserializer are one indexed part-select each on the shared counter.

## Test plan
- Clean miss: `miss=1`, `miss_addr=0x0000_1040`, `wen_back=0`, `mem_ready=1`, memory word at A = A ^ 0xA5A5_A5A5 -> `accept` at cycle 1, 16 reads at 0x1040..0x107C, `wen_fill` at cycle 17 with `wfill[31:0]=0xA5A5_B5E5`, no `fin`.
- Miss with writeback: `waddr=0x0000_2040`, `wback` word i = i -> writes 0x2040..0x207C with data 0..15, `fin` at cycle 17, reads follow, `wen_fill` at cycle 34.
- Stalls: `mem_ready` low on every other cycle during RD -> same `wfill`, `wen_fill` delayed by 16 cycles, `mem_addr` stable while stalled.
- Stray `wen_back`: `wen_back=1`, `miss=0` in IDLE -> no bus activity, no `fin`.
- Reset mid-WB: drive `rst=0` at beat 7 -> next cycle `mem_req=0`, state IDLE, all outputs 0; a subsequent clean miss completes normally.
- Back-to-back: second `miss` held high during FILL -> second `accept` exactly 2 cycles after the first `wen_fill`.
